// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 = core, port 1 = DMA/debug loader.
// Build macro DMEM_ARB_FAIRNESS_EN bounds consecutive core grants while the DMA port is waiting.
module dmem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LAT         = 1,
  parameter int MAX_CORE_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("dmem_arbiter: MEM_LAT must be 1..4");
  end
  if (MAX_CORE_STREAK < 1 || MAX_CORE_STREAK > 15) begin : g_bad_streak
    $error("dmem_arbiter: MAX_CORE_STREAK must be 1..15");
  end

  typedef enum logic { IDLE, WAIT } state_t;
  typedef enum logic { OWN_CORE, OWN_DMA } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] core_rdata_q, dma_rdata_q;
  logic              rd_done, arb_ok, force_dma, core_win, dma_win;

  // The last WAIT cycle returns the read data and may already accept the next access.
  assign rd_done = (state_q == WAIT) && (cnt_q == '0);
  // Grants are combinational from req, so they are masked while reset is held.
  assign arb_ok  = !reset && ((state_q == IDLE) || rd_done);

`ifdef DMEM_ARB_FAIRNESS_EN
  logic [3:0] streak_q;

  assign force_dma = core_req && dma_req && (streak_q == 4'(MAX_CORE_STREAK));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
    end else if (dma_win || !dma_req) begin
      streak_q <= '0;
    end else if (core_win && streak_q != 4'hF) begin
      streak_q <= streak_q + 4'd1;
    end
  end
`else
  assign force_dma = 1'b0;
`endif

  assign core_win = arb_ok && core_req && !force_dma;
  assign dma_win  = arb_ok && dma_req && !core_win;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_win) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dma_win) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign core_gnt    = core_win;
  assign dma_gnt     = dma_win;
  assign mem_en      = core_win || dma_win;
  assign busy        = (state_q == WAIT);
  assign core_rvalid = rd_done && (owner_q == OWN_CORE);
  assign dma_rvalid  = rd_done && (owner_q == OWN_DMA);
  assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
  assign dma_rdata   = dma_rvalid  ? mem_rdata : dma_rdata_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (state_q == WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (rd_done) begin
      state_d = IDLE;
    end
    if (mem_en && !mem_we) begin
      state_d = WAIT;
      cnt_d   = CNT_W'(MEM_LAT - 1);
      owner_d = dma_win ? OWN_DMA : OWN_CORE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the read-data holding registers are cleared by reset too; they are architectural outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CORE;
      cnt_q        <= '0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (rd_done) begin
        if (owner_q == OWN_DMA) dma_rdata_q  <= mem_rdata;
        else                    core_rdata_q <= mem_rdata;
      end
    end
  end

endmodule
